// File: rtl/vxe_txn_pkg.sv
// Shared widths and field offsets for the request transaction vectors.
// Used by the ingress queue and by the downstream request decoder.
package vxe_txn_pkg;

    localparam int VXE_TXN_W = 44;
    localparam int VXE_DAT_W = 72;

    localparam int TXNID_HI = 43;
    localparam int TXNID_LO = 38;
    localparam int RNW_BIT  = 37;
    localparam int ADDR_HI  = 36;
    localparam int BEN_HI   = 71;
    localparam int BEN_LO   = 64;

endpackage

// File: rtl/vxe_txnreq_queue_if.sv
// Request bus between the interconnect, the ingress queue and its consumer.
// The slave modport is the queue's view; master is the surrounding logic's view.
interface vxe_txnreq_queue_if
    import vxe_txn_pkg::*;
#(
    parameter int TXN_W = VXE_TXN_W,
    parameter int DAT_W = VXE_DAT_W
);
    logic [TXN_W-1:0] i_req_vec_txn;
    logic [DAT_W-1:0] i_req_vec_dat;
    logic             i_req_valid;
    logic             o_req_rdy;
    logic [TXN_W-1:0] o_req_vec_txn;
    logic [DAT_W-1:0] o_req_vec_dat;
    logic             o_req_valid;
    logic             i_req_rdy;

    modport slave (
        input  i_req_vec_txn, i_req_vec_dat, i_req_valid, i_req_rdy,
        output o_req_rdy, o_req_vec_txn, o_req_vec_dat, o_req_valid
    );

    modport master (
        output i_req_vec_txn, i_req_vec_dat, i_req_valid, i_req_rdy,
        input  o_req_rdy, o_req_vec_txn, o_req_vec_dat, o_req_valid
    );
endinterface

// File: rtl/vxe_txnreq_qmem.sv
// Queue storage: 1W/1R register array, synchronous write, combinational read.
// Contents are deliberately left unreset; occupancy is tracked by the queue.
module vxe_txnreq_qmem #(
    parameter int DEPTH_POW2 = 2,
    parameter int W          = 116
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_POW2-1:0] waddr,
    input  logic [W-1:0]          wdata,
    input  logic [DEPTH_POW2-1:0] raddr,
    output logic [W-1:0]          rdata
);
    localparam int DEPTH = 1 << DEPTH_POW2;

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vxe_txnreq_queue.sv
// Show-ahead ingress request queue feeding the transaction decoder.
// Read requests have their data vector zeroed on entry.
module vxe_txnreq_queue
    import vxe_txn_pkg::*;
#(
    parameter int DEPTH_POW2 = 2,
    parameter int TXN_W      = VXE_TXN_W,
    parameter int DAT_W      = VXE_DAT_W
) (
    input  logic                  clk,
    input  logic                  nrst,
    vxe_txnreq_queue_if.slave     bus,
    output logic [DEPTH_POW2:0]   o_count,
    output logic                  o_err_push_full
);
    localparam int                  ENT_W   = TXN_W + DAT_W;
    localparam logic [DEPTH_POW2:0] PTR_ONE = 1;

    // Pointers carry an extra wrap bit to distinguish full from empty.
    logic [DEPTH_POW2:0] wr_ptr;
    logic [DEPTH_POW2:0] rd_ptr;
    logic                empty;
    logic                full;
    logic                we;
    logic                re;
    logic [DAT_W-1:0]    dat_masked;
    logic [ENT_W-1:0]    wdata;
    logic [ENT_W-1:0]    rdata;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_POW2-1:0] == rd_ptr[DEPTH_POW2-1:0]) &&
                   (wr_ptr[DEPTH_POW2] != rd_ptr[DEPTH_POW2]);

    // Ready depends only on registered state: no pass-through when full.
    assign bus.o_req_rdy   = ~full;
    assign bus.o_req_valid = ~empty;

    assign we = bus.i_req_valid & bus.o_req_rdy;
    assign re = bus.o_req_valid & bus.i_req_rdy;

    assign dat_masked = bus.i_req_vec_txn[RNW_BIT] ? '0 : bus.i_req_vec_dat;
    assign wdata      = {bus.i_req_vec_txn, dat_masked};

    assign bus.o_req_vec_txn = empty ? '0 : rdata[ENT_W-1 -: TXN_W];
    assign bus.o_req_vec_dat = empty ? '0 : rdata[DAT_W-1:0];

    assign o_count = wr_ptr - rd_ptr;

    vxe_txnreq_qmem #(
        .DEPTH_POW2 (DEPTH_POW2),
        .W          (ENT_W)
    ) u_qmem (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr[DEPTH_POW2-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr[DEPTH_POW2-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            o_err_push_full <= 1'b0;
        end else begin
            if (we) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (re) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // Sticky trap for a write that slips past the full gate.
            if (we && full) begin
                o_err_push_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vxe_txnreq_queue.sv
// Directed self-checking bench for the ingress request queue.
module tb_vxe_txnreq_queue;
    import vxe_txn_pkg::*;

    logic       clk;
    logic       nrst;
    logic [2:0] count;
    logic       err;
    int         n_checks;
    int         n_fail;

    vxe_txnreq_queue_if bus_if ();

    vxe_txnreq_queue #(.DEPTH_POW2(2)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .bus             (bus_if),
        .o_count         (count),
        .o_err_push_full (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [43:0] mk_txn(input logic [5:0] id, input logic rnw, input logic [36:0] a);
        return {id, rnw, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        bus_if.i_req_valid   = 1'b0;
        bus_if.i_req_rdy     = 1'b0;
        bus_if.i_req_vec_txn = '0;
        bus_if.i_req_vec_dat = '0;
        tick();
        tick();
        n_checks++; if (bus_if.o_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus_if.o_req_valid); end
        n_checks++; if (bus_if.o_req_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got %b want 1", bus_if.o_req_rdy); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (bus_if.o_req_vec_txn !== 44'h0) begin n_fail++; $display("FAIL reset_txn got %h want 0", bus_if.o_req_vec_txn); end
        n_checks++; if (bus_if.o_req_vec_dat !== 72'h0) begin n_fail++; $display("FAIL reset_dat got %h want 0", bus_if.o_req_vec_dat); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        nrst = 1'b1;
        tick();
        n_checks++; if (bus_if.o_req_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL idle got valid=%b count=%0d want 0/0", bus_if.o_req_valid, count); end
    endtask

    task automatic test_write_push();
        logic [43:0] t;
        t = mk_txn(6'h05, 1'b0, 37'h1_0000_0040);
        bus_if.i_req_vec_txn = t;
        bus_if.i_req_vec_dat = {8'hFF, 64'hDEAD_BEEF_0123_4567};
        bus_if.i_req_valid   = 1'b1;
        bus_if.i_req_rdy     = 1'b0;
        #1;
        n_checks++; if (bus_if.o_req_valid !== 1'b0) begin n_fail++; $display("FAIL no_bypass got valid=%b want 0", bus_if.o_req_valid); end
        tick();
        bus_if.i_req_valid = 1'b0;
        n_checks++; if (bus_if.o_req_valid !== 1'b1) begin n_fail++; $display("FAIL wr_valid got %b want 1", bus_if.o_req_valid); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL wr_count got %0d want 1", count); end
        n_checks++; if (bus_if.o_req_vec_dat !== 72'hFF_DEADBEEF01234567) begin n_fail++; $display("FAIL wr_dat got %h want ffdeadbeef01234567", bus_if.o_req_vec_dat); end
        n_checks++; if (bus_if.o_req_vec_txn !== t) begin n_fail++; $display("FAIL wr_txn got %h want %h", bus_if.o_req_vec_txn, t); end
    endtask

    task automatic test_read_mask();
        logic [43:0] t;
        t = mk_txn(6'h2A, 1'b1, 37'h0_0000_0100);
        bus_if.i_req_vec_txn = t;
        bus_if.i_req_vec_dat = 72'hAA_5555_5555_5555_5555;
        bus_if.i_req_valid   = 1'b1;
        tick();
        bus_if.i_req_valid = 1'b0;
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL rd_count got %0d want 2", count); end
        n_checks++; if (bus_if.o_req_vec_txn[43:38] !== 6'h05) begin n_fail++; $display("FAIL rd_head_hold got %h want 05", bus_if.o_req_vec_txn[43:38]); end
        bus_if.i_req_rdy = 1'b1;
        tick();
        bus_if.i_req_rdy = 1'b0;
        n_checks++; if (bus_if.o_req_vec_txn !== t) begin n_fail++; $display("FAIL rd_txn got %h want %h", bus_if.o_req_vec_txn, t); end
        n_checks++; if (bus_if.o_req_vec_dat !== 72'h0) begin n_fail++; $display("FAIL rd_mask got %h want 0", bus_if.o_req_vec_dat); end
        bus_if.i_req_rdy = 1'b1;
        tick();
        bus_if.i_req_rdy = 1'b0;
        n_checks++; if (bus_if.o_req_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL rd_drain got valid=%b count=%0d want 0/0", bus_if.o_req_valid, count); end
    endtask

    task automatic test_full();
        bus_if.i_req_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus_if.i_req_vec_txn = mk_txn(6'(i), 1'b0, 37'(i * 16));
            bus_if.i_req_vec_dat = 72'(i);
            bus_if.i_req_valid   = 1'b1;
            tick();
        end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", count); end
        n_checks++; if (bus_if.o_req_rdy !== 1'b0) begin n_fail++; $display("FAIL full_rdy got %b want 0", bus_if.o_req_rdy); end
        bus_if.i_req_vec_txn = mk_txn(6'd5, 1'b0, 37'h50);
        bus_if.i_req_vec_dat = 72'd5;
        tick();
        n_checks++; if (count !== 3'd4 || bus_if.o_req_vec_txn[43:38] !== 6'd1) begin n_fail++; $display("FAIL full_holdoff got count=%0d head=%0d want 4/1", count, bus_if.o_req_vec_txn[43:38]); end
        bus_if.i_req_rdy = 1'b1;
        tick();
        bus_if.i_req_rdy = 1'b0;
        n_checks++; if (count !== 3'd3 || bus_if.o_req_rdy !== 1'b1) begin n_fail++; $display("FAIL full_pop_only got count=%0d rdy=%b want 3/1", count, bus_if.o_req_rdy); end
        n_checks++; if (bus_if.o_req_vec_txn[43:38] !== 6'd2) begin n_fail++; $display("FAIL full_head2 got %0d want 2", bus_if.o_req_vec_txn[43:38]); end
        tick();
        bus_if.i_req_valid = 1'b0;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_fifth got count=%0d want 4", count); end
        bus_if.i_req_rdy = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            n_checks++;
            if (bus_if.o_req_vec_txn[43:38] !== 6'(i) || bus_if.o_req_vec_dat !== 72'(i)) begin
                n_fail++;
                $display("FAIL full_order got id=%0d dat=%0h want %0d", bus_if.o_req_vec_txn[43:38], bus_if.o_req_vec_dat, i);
            end
            tick();
        end
        bus_if.i_req_rdy = 1'b0;
        n_checks++; if (bus_if.o_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty got valid=%b want 0", bus_if.o_req_valid); end
    endtask

    task automatic test_stream();
        bus_if.i_req_rdy   = 1'b1;
        bus_if.i_req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_if.i_req_vec_txn = mk_txn(6'(16 + i), 1'b0, 37'h100);
            bus_if.i_req_vec_dat = 72'(i);
            tick();
            n_checks++;
            if (bus_if.o_req_valid !== 1'b1 || bus_if.o_req_vec_txn[43:38] !== 6'(16 + i) || count > 3'd1) begin
                n_fail++;
                $display("FAIL stream got valid=%b id=%0d count=%0d want 1/%0d/<=1", bus_if.o_req_valid, bus_if.o_req_vec_txn[43:38], count, 16 + i);
            end
        end
        bus_if.i_req_valid = 1'b0;
        tick();
        bus_if.i_req_rdy = 1'b0;
        n_checks++; if (bus_if.o_req_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL stream_end got valid=%b count=%0d want 0/0", bus_if.o_req_valid, count); end
    endtask

    task automatic test_reset_mid();
        bus_if.i_req_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_if.i_req_vec_txn = mk_txn(6'(48 + i), 1'b0, 37'h200);
            bus_if.i_req_vec_dat = 72'hAB;
            bus_if.i_req_valid   = 1'b1;
            tick();
        end
        bus_if.i_req_valid = 1'b0;
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL mid_fill got count=%0d want 3", count); end
        #2;
        nrst = 1'b0;
        #1;
        n_checks++; if (bus_if.o_req_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL mid_async got valid=%b count=%0d want 0/0", bus_if.o_req_valid, count); end
        n_checks++; if (bus_if.o_req_rdy !== 1'b1 || bus_if.o_req_vec_txn !== 44'h0) begin n_fail++; $display("FAIL mid_outs got rdy=%b txn=%h want 1/0", bus_if.o_req_rdy, bus_if.o_req_vec_txn); end
        tick();
        nrst = 1'b1;
        bus_if.i_req_vec_txn = mk_txn(6'h3F, 1'b0, 37'h300);
        bus_if.i_req_vec_dat = 72'h12;
        bus_if.i_req_valid   = 1'b1;
        tick();
        bus_if.i_req_valid = 1'b0;
        n_checks++; if (count !== 3'd1 || bus_if.o_req_vec_txn[43:38] !== 6'h3F) begin n_fail++; $display("FAIL mid_after got count=%0d id=%h want 1/3f", count, bus_if.o_req_vec_txn[43:38]); end
        bus_if.i_req_rdy = 1'b1;
        tick();
        bus_if.i_req_rdy = 1'b0;
        n_checks++; if (bus_if.o_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_only_one got valid=%b want 0", bus_if.o_req_valid); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_sticky got %b want 0", err); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_write_push();
        test_read_mask();
        test_full();
        test_stream();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
